// File: rtl/snn_inference_ctrl.sv
// Sequencing controller for the colour-classification spiking layer.
// Clears the neurons, runs the encoder, counts output spikes per class and picks the winner.
module snn_inference_ctrl #(
    parameter int N_CLASSES = 3,
    parameter int T_STEPS   = 64,
    parameter int PIPE_LAT  = 6,
    parameter int CNT_W     = 8
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 start,
    input  logic                                                 abort,
    input  logic [N_CLASSES-1:0]                                 spike_in,
    output logic                                                 busy,
    output logic                                                 enc_en,
    output logic [N_CLASSES-1:0]                                 neuron_reset,
    output logic [15:0]                                          timestep,
    output logic                                                 done,
    output logic [$clog2(N_CLASSES > 1 ? N_CLASSES : 2)-1:0]     class_out,
    output logic                                                 no_spike,
    output logic [N_CLASSES*CNT_W-1:0]                           spike_cnt
);

    localparam int CLS_W = $clog2(N_CLASSES > 1 ? N_CLASSES : 2);
    localparam logic [15:0] TS_LAST = 16'(T_STEPS - 1);
    localparam logic [3:0]  DR_LAST = 4'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        ts_q, ts_d;
    logic [3:0]         drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q [N_CLASSES];
    logic [CNT_W-1:0]   cnt_d [N_CLASSES];
    logic [CLS_W-1:0]   cls_q, cls_d;
    logic               nospk_q, nospk_d;
    logic [CLS_W-1:0]   best_idx;
    logic [CNT_W-1:0]   best_val;
    logic               any_spk;
    logic               counting;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                ts_d    = '0;
                drain_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ts_q == TS_LAST) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    ts_d = ts_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DR_LAST) state_d = S_DECIDE;
                else                    drain_d = drain_q + 4'd1;
            end
            S_DECIDE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && (state_q == S_CLEAR || state_q == S_RUN ||
                      state_q == S_DRAIN || state_q == S_DECIDE)) begin
            state_d = S_IDLE;
        end
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = cnt_q[0];
        any_spk  = 1'b0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (cnt_q[i] != '0) any_spk = 1'b1;
            if (cnt_q[i] > best_val) begin
                best_val = cnt_q[i];
                best_idx = CLS_W'(i);
            end
        end
    end

    assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

    always_comb begin
        cls_d   = cls_q;
        nospk_d = nospk_q;
        for (int i = 0; i < N_CLASSES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (state_q == S_CLEAR)          cnt_d[i] = '0;
            else if (counting && spike_in[i]) cnt_d[i] = sat_inc(cnt_q[i]);
        end
        if (state_q == S_CLEAR) begin
            cls_d   = '0;
            nospk_d = 1'b0;
        end else if (state_q == S_DECIDE && !abort) begin
            cls_d   = any_spk ? best_idx : '0;
            nospk_d = !any_spk;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ts_q    <= '0;
            drain_q <= '0;
            cls_q   <= '0;
            nospk_q <= 1'b0;
            for (int i = 0; i < N_CLASSES; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            drain_q <= drain_d;
            cls_q   <= cls_d;
            nospk_q <= nospk_d;
            for (int i = 0; i < N_CLASSES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Outputs decode only registered state, never an input.
    assign busy         = (state_q != S_IDLE);
    assign enc_en       = (state_q == S_RUN);
    assign neuron_reset = {N_CLASSES{(state_q == S_IDLE) || (state_q == S_CLEAR)}};
    assign timestep     = ts_q;
    assign done         = (state_q == S_DONE);
    assign class_out    = cls_q;
    assign no_spike     = nospk_q;

    for (genvar g = 0; g < N_CLASSES; g++) begin : g_cnt
        assign spike_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: doc/snn_inference_ctrl.md
# snn_inference_ctrl

Sequencing controller for the colour-classification spiking layer. Per sample it clears the output neurons (one per colour class), enables the upstream spike encoder for a fixed number of timesteps, and counts each neuron's `spike_out` pulses. It waits for the neuron adder pipeline to drain, then selects the class with the most spikes. It sits between the pixel/encoder front-end and the result/readout logic and owns every `neuron_reset` line in the layer.

## Interface
- `N_CLASSES`, default 3: number of output neurons/classes (R, G, B).
- `T_STEPS`, default 64: encoder-enabled timesteps per sample, range 1..65535.
- `PIPE_LAT`, default 6: neuron input-spike-to-`spike_out` latency in cycles, range 1..15.
- `CNT_W`, default 8: width of each per-class spike counter.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high; forces all state and outputs to their reset values.
- `start`, in, 1: request to classify one sample; sampled only in IDLE.
- `abort`, in, 1: cancels the sample in progress.
- `spike_in`, in, N_CLASSES: `spike_out` of each class neuron; bit i is class i.
- `busy`, out, 1: high in every state except IDLE.
- `enc_en`, out, 1: encoder enable; the encoder emits one spike vector per cycle while high.
- `neuron_reset`, out, N_CLASSES: per-neuron voltage clear, all bits driven identically.
- `timestep`, out, 16: index of the current RUN cycle, 0..T_STEPS-1.
- `done`, out, 1: single-cycle result strobe.
- `class_out`, out, clog2(N_CLASSES): index of the winning class.
- `no_spike`, out, 1: high when every count was zero.
- `spike_cnt`, out, N_CLASSES*CNT_W: concatenated counts; class i occupies bits [i*CNT_W +: CNT_W].

## Operation
- The FSM has six states: IDLE, CLEAR, RUN, DRAIN, DECIDE, DONE.
- IDLE:
  - `neuron_reset` is all ones, holding every neuron voltage at 0. `enc_en`=0, `busy`=0.
  - `start`=1 moves to CLEAR.
- CLEAR, 1 cycle:
  - `neuron_reset` is all ones.
  - Counters, `class_out` and `no_spike` are zeroed.
  - Moves to RUN.
- RUN, exactly T_STEPS cycles:
  - `neuron_reset`=0, `enc_en`=1, `timestep` increments from 0.
  - After the cycle with `timestep`=T_STEPS-1, moves to DRAIN.
- DRAIN, exactly PIPE_LAT cycles:
  - `enc_en`=0, `neuron_reset`=0.
  - Counting continues so spikes from the last encoder vectors are captured.
- Counting:
  - Active in RUN and DRAIN only. Each cycle, `spike_cnt[i]` increments by 1 when `spike_in[i]`=1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - `spike_in` is ignored in all other states.
- DECIDE, 1 cycle:
  - `class_out` is the index of the maximum count.
  - Ties go to the lowest index.
  - When all counts are 0: `no_spike`=1 and `class_out`=0.
- DONE, 1 cycle:
  - `done`=1, then returns to IDLE.
  - `class_out`, `no_spike` and `spike_cnt` hold until the next CLEAR.
- `start` handling:
  - `start` while `busy`=1 is ignored and not queued.
  - `start` held high continuously re-triggers at every IDLE cycle, giving back-to-back samples.
- `abort`:
  - In CLEAR, RUN, DRAIN or DECIDE, the next state is IDLE.
  - `done` is not asserted, and `neuron_reset` goes high on entering IDLE.
  - Counters keep their partial values; `class_out` and `no_spike` are not updated.
  - `abort` in IDLE or DONE has no effect.
  - `abort` and `start` together in IDLE: `start` wins.

## Timing
- Reset values:
  - State=IDLE, `busy`=0, `enc_en`=0, `neuron_reset`=all ones.
  - `timestep`=0, `done`=0, `class_out`=0, `no_spike`=0, `spike_cnt`=0.
- All outputs are registered; no combinational path from input to output.
- Sequence after `start` is sampled at edge E0:
  - CLEAR in cycle E0+1.
  - RUN in E0+2 .. E0+T_STEPS+1.
  - DRAIN through E0+T_STEPS+PIPE_LAT+1.
  - DECIDE in E0+T_STEPS+PIPE_LAT+2.
  - `done` high in cycle E0+T_STEPS+PIPE_LAT+3.
- Throughput: with `start` held high, the next CLEAR follows DONE by one IDLE cycle, giving T_STEPS+PIPE_LAT+4 cycles per sample.
- `reset` mid-sample: immediate return to reset values and no `done`.

## Test plan
- T_STEPS=8, PIPE_LAT=6, `spike_in`=3'b010 held throughout a sample -> `done` exactly 17 cycles after the `start` edge; counts {0,14,0}; `class_out`=1; `no_spike`=0.
- Counts equal at 5/5/2 (bits 0 and 1 pulsed 5 times each) -> `class_out`=0 (lowest-index tie-break).
- `spike_in` held 0 -> `no_spike`=1, `class_out`=0, all counts 0, `done` still pulses.
- CNT_W=4, bit 2 held high for T_STEPS=32 -> count for class 2 saturates at 15; `class_out`=2.
- `abort` asserted at `timestep`=3 -> IDLE next cycle, `neuron_reset` all ones, no `done`. A new `start` then completes normally.
- `start` pulsed again during RUN -> ignored; exactly one `done`. `reset` asserted during DRAIN -> all outputs at reset values within the same cycle, and `done` never pulses.
